// File: rtl/clk_div_ctrl.sv
// Reconfiguration sequencer and round-robin arbiter for the shared clock divider.
// Optional build macro: CLK_DIV_CTRL_MIN_CLAMP_EN (clamp captured divisors below 2 up to 2).
module clk_div_ctrl #(
    parameter int          NUM_REQ       = 4,
    parameter int          DRAIN_CYCLES  = 4,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] RESET_DIV     = 16'd2,
    localparam int         OW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  div_req,
    input  logic                   stop,
    output logic [NUM_REQ-1:0]     ack,
    output logic [15:0]            divider,
    output logic                   en,
    output logic                   busy,
    output logic [OW-1:0]          owner
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [15:0]          hold_q, hold_d;
    logic [15:0]          divider_q, divider_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 ack_pend_q, ack_pend_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;

    logic [15:0]          div_arr_s [NUM_REQ];
    logic [NUM_REQ-1:0]   eligible_s;
    logic                 grant_vld_s;
    logic [OW-1:0]        grant_idx_s;
    logic [OW-1:0]        grant_nxt_s;
    logic [OW-1:0]        scan_idx_s;
    logic [15:0]          grant_div_s;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
`ifdef CLK_DIV_CTRL_MIN_CLAMP_EN
        return (d < 16'd2) ? 16'd2 : d;
`else
        return d;
`endif
    endfunction

    // Split the packed request bus into one divisor per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            div_arr_s[i] = div_req[16*i +: 16];
        end
    end

    // Round-robin pick: scan from rr_ptr; the lowest offset with an eligible request wins
    always_comb begin
        eligible_s  = req & ~ack_q;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        scan_idx_s  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx_s  = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
            grant_idx_s = eligible_s[scan_idx_s] ? scan_idx_s : grant_idx_s;
            grant_vld_s = grant_vld_s | eligible_s[scan_idx_s];
        end
        grant_nxt_s = OW'((int'(grant_idx_s) + 1) % NUM_REQ);
        grant_div_s = clamp_div(div_arr_s[grant_idx_s]);
    end

    // Sequencer next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        divider_d  = divider_q;
        valid_d    = valid_q;
        ack_pend_d = ack_pend_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (stop) begin
                    state_d = S_HALT;
                end else if (grant_vld_s) begin
                    state_d    = S_DRAIN;
                    cnt_d      = 8'd0;
                    hold_d     = grant_div_s;
                    owner_d    = grant_idx_s;
                    rr_ptr_d   = grant_nxt_s;
                    ack_pend_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LOAD: begin
                divider_d = hold_q;
                valid_d   = 1'b1;
                state_d   = S_SETTLE;
                cnt_d     = 8'd0;
            end
            S_SETTLE: begin
                // A resume from HALT reaches RUN with ack_pend clear, so no ack is issued
                if (cnt_q == SETTLE_LAST) begin
                    state_d        = S_RUN;
                    cnt_d          = 8'd0;
                    ack_d[owner_q] = ack_pend_q;
                    ack_pend_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HALT: begin
                if (!stop) begin
                    if (valid_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_d   = (state_d == S_RUN);
        busy_d = (state_d != S_IDLE) && (state_d != S_RUN);
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            hold_q     <= RESET_DIV;
            divider_q  <= RESET_DIV;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ack_pend_q <= 1'b0;
            ack_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            divider_q  <= divider_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ack_pend_q <= ack_pend_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign ack     = ack_q;
    assign divider = divider_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized traffic
// compared against a timestamp-based reference model of the reconfiguration sequence.
module tb_clk_div_ctrl;
    localparam int          NR   = 4;
    localparam int          DR   = 4;
    localparam int          ST   = 2;
    localparam logic [15:0] RDIV = 16'd2;

    logic             clk_in  = 1'b0;
    logic             rst_n   = 1'b0;
    logic             stop    = 1'b0;
    logic [NR-1:0]    req     = '0;
    logic [16*NR-1:0] div_req = '0;
    logic [NR-1:0]    ack;
    logic [15:0]      divider;
    logic             en;
    logic             busy;
    logic [1:0]       owner;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a sequence is a grant time plus fixed offsets to load and run
    int          cyc = 0;
    logic [15:0] m_div, m_hold;
    logic        m_en, m_busy, m_valid, m_in_seq, m_seq_ack, m_seq_load, m_halted;
    logic [NR-1:0] m_ack;
    int          m_owner, m_rr, m_seq_t0, m_seq_end;

    clk_div_ctrl #(
        .NUM_REQ(NR), .DRAIN_CYCLES(DR), .SETTLE_CYCLES(ST), .RESET_DIV(RDIV)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req), .div_req(div_req), .stop(stop),
        .ack(ack), .divider(divider), .en(en), .busy(busy), .owner(owner)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] exp_clamp(input logic [15:0] d);
`ifdef CLK_DIV_CTRL_MIN_CLAMP_EN
        return (d < 16'd2) ? 16'd2 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_div = RDIV; m_hold = RDIV; m_en = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
        m_in_seq = 1'b0; m_seq_ack = 1'b0; m_seq_load = 1'b0; m_halted = 1'b0;
        m_ack = '0; m_owner = 0; m_rr = 0; m_seq_t0 = 0; m_seq_end = 0;
    endtask

    task automatic model_edge();
        logic [NR-1:0] prev_ack;
        logic found;
        int i;
        prev_ack = m_ack;
        m_ack = '0;
        found = 1'b0;
        cyc++;
        if (m_in_seq) begin
            if (m_seq_load && cyc == m_seq_t0 + DR + 1) begin
                m_div = m_hold;
                m_valid = 1'b1;
            end
            if (cyc == m_seq_end) begin
                m_in_seq = 1'b0;
                m_en = 1'b1;
                if (m_seq_ack) m_ack[m_owner] = 1'b1;
            end
        end else if (m_halted) begin
            if (!stop) begin
                m_halted = 1'b0;
                if (m_valid) begin
                    m_in_seq = 1'b1; m_seq_load = 1'b0; m_seq_ack = 1'b0;
                    m_seq_t0 = cyc; m_seq_end = cyc + ST;
                end
            end
        end else if (stop) begin
            m_halted = 1'b1;
            m_en = 1'b0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                i = (m_rr + k) % NR;
                if (!found && req[i] && !prev_ack[i]) begin
                    found = 1'b1;
                    m_hold = exp_clamp(div_req[16*i +: 16]);
                    m_owner = i;
                    m_rr = (i + 1) % NR;
                    m_in_seq = 1'b1; m_seq_load = 1'b1; m_seq_ack = 1'b1;
                    m_seq_t0 = cyc; m_seq_end = cyc + DR + 1 + ST;
                    m_en = 1'b0;
                end
            end
        end
        m_busy = m_in_seq || m_halted;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_vec++; if (divider !== RDIV) begin n_err++; $display("FAIL reset_divider: got %0d expected %0d", divider, RDIV); end
        n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b expected 0", en); end
        n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        logic got;
        req[0] = 1'b1;
        div_req[15:0] = 16'd10;
        tick();
        n_vec++; if (en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_grant: got en=%b busy=%b expected en=0 busy=1", en, busy); end
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (lat == DR) begin
                n_vec++; if (divider !== RDIV) begin n_err++; $display("FAIL single_preload: got %0d expected %0d", divider, RDIV); end
            end
            if (lat == DR + 1) begin
                n_vec++; if (divider !== 16'd10) begin n_err++; $display("FAIL single_load: got %0d expected 10", divider); end
            end
            if (ack !== 4'b0000) got = 1'b1;
            else begin
                n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL single_en_low: got %b expected 0 at lat %0d", en, lat); end
            end
        end
        n_vec++; if (lat != DR + 1 + ST) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", lat, DR + 1 + ST); end
        n_vec++; if (ack !== 4'b0001 || en !== 1'b1) begin n_err++; $display("FAIL single_ack: got ack=%b en=%b expected ack=0001 en=1", ack, en); end
        req[0] = 1'b0;
        tick();
        n_vec++; if (ack !== 4'b0000 || en !== 1'b1 || divider !== 16'd10) begin
            n_err++; $display("FAIL single_run: got ack=%b en=%b div=%0d expected 0000 1 10", ack, en, divider);
        end
    endtask

    task automatic test_round_robin();
        int last_t;
        int lat;
        logic [15:0] prev_div;
        logic [15:0] dv;
        apply_reset();
        for (int i = 0; i < NR; i++) begin
            dv = 16'(100 + 11 * i);
            div_req[16*i +: 16] = dv;
        end
        req = 4'b1111;
        last_t = 0;
        prev_div = divider;
        for (int j = 0; j < NR; j++) begin
            lat = 0;
            while (ack === 4'b0000 && lat < 30) begin
                tick();
                lat++;
                n_vec++; if (en === 1'b1 && divider !== prev_div) begin n_err++; $display("FAIL rr_en_on_change: got div %0d->%0d with en=1 expected stable", prev_div, divider); end
                prev_div = divider;
            end
            n_vec++; if (ack !== 4'(1 << j)) begin n_err++; $display("FAIL rr_order: got ack=%b expected %b", ack, 4'(1 << j)); end
            n_vec++; if (owner !== 2'(j)) begin n_err++; $display("FAIL rr_owner: got %0d expected %0d", owner, j); end
            dv = 16'(100 + 11 * j);
            n_vec++; if (divider !== dv) begin n_err++; $display("FAIL rr_divider: got %0d expected %0d", divider, dv); end
            if (j > 0) begin
                n_vec++; if (cyc - last_t != 8) begin n_err++; $display("FAIL rr_spacing: got %0d expected 8", cyc - last_t); end
            end
            last_t = cyc;
            req[j] = 1'b0;
            if (j < NR - 1) begin
                tick();
                prev_div = divider;
            end
        end
    endtask

    task automatic test_stop_halt();
        int lat;
        req[1] = 1'b1;
        div_req[31:16] = 16'd6;
        lat = 0;
        tick();
        while (ack[1] !== 1'b1 && lat < 30) begin tick(); lat++; end
        n_vec++; if (ack !== 4'b0010 || divider !== 16'd6) begin n_err++; $display("FAIL halt_setup: got ack=%b div=%0d expected 0010 6", ack, divider); end
        req[1] = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        n_vec++; if (en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL halt_enter: got en=%b busy=%b expected 0 1", en, busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (en !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
                n_err++; $display("FAIL halt_hold: got en=%b busy=%b ack=%b expected 0 1 0000", en, busy, ack);
            end
        end
        stop = 1'b0;
        tick();
        tick();
        n_vec++; if (en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL halt_settle: got en=%b busy=%b expected 0 1", en, busy); end
        tick();
        n_vec++; if (en !== 1'b1 || ack !== 4'b0000 || divider !== 16'd6 || busy !== 1'b0) begin
            n_err++; $display("FAIL halt_resume: got en=%b ack=%b div=%0d busy=%b expected 1 0000 6 0", en, ack, divider, busy);
        end
    endtask

    task automatic test_stop_with_req();
        int lat;
        stop = 1'b1;
        req[2] = 1'b1;
        div_req[47:32] = 16'h0123;
        tick();
        n_vec++; if (en !== 1'b0 || busy !== 1'b1 || owner !== 2'd1) begin
            n_err++; $display("FAIL stopreq_halt: got en=%b busy=%b owner=%0d expected 0 1 1", en, busy, owner);
        end
        tick();
        tick();
        n_vec++; if (ack !== 4'b0000 || owner !== 2'd1) begin n_err++; $display("FAIL stopreq_nogrant: got ack=%b owner=%0d expected 0000 1", ack, owner); end
        stop = 1'b0;
        lat = 0;
        while (ack === 4'b0000 && lat < 30) begin tick(); lat++; end
        n_vec++; if (lat != 1 + ST + 1 + DR + 1 + ST) begin n_err++; $display("FAIL stopreq_latency: got %0d expected %0d", lat, 1 + ST + 1 + DR + 1 + ST); end
        n_vec++; if (ack !== 4'b0100 || divider !== 16'h0123 || owner !== 2'd2) begin
            n_err++; $display("FAIL stopreq_ack: got ack=%b div=%h owner=%0d expected 0100 0123 2", ack, divider, owner);
        end
        req[2] = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        int lat;
        logic [15:0] want;
        want = exp_clamp(16'd1);
        req[1] = 1'b1;
        div_req[31:16] = 16'd1;
        lat = 0;
        tick();
        while (ack[1] !== 1'b1 && lat < 30) begin tick(); lat++; end
        n_vec++; if (ack !== 4'b0010 || divider !== want) begin n_err++; $display("FAIL clamp: got ack=%b div=%0d expected 0010 %0d", ack, divider, want); end
        req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req[3] = 1'b1;
        div_req[63:48] = 16'd100;
        tick();
        for (int k = 0; k < DR + 1; k++) tick();
        n_vec++; if (divider !== 16'd100 || busy !== 1'b1 || en !== 1'b0) begin
            n_err++; $display("FAIL midrst_setup: got div=%0d busy=%b en=%b expected 100 1 0", divider, busy, en);
        end
        rst_n = 1'b0;
        req[3] = 1'b0;
        model_reset();
        #1;
        n_vec++; if (divider !== RDIV || en !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || owner !== 2'd0) begin
            n_err++; $display("FAIL midrst_values: got div=%0d en=%b busy=%b ack=%b owner=%0d expected 2 0 0 0000 0", divider, en, busy, ack, owner);
        end
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_vec++; if (ack !== 4'b0000 || en !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL midrst_idle: got ack=%b en=%b busy=%b expected 0000 0 0", ack, en, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] prev_div;
        prev_div = divider;
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) begin
                apply_reset();
                prev_div = divider;
            end
            tick();
            n_vec++; if (divider !== m_div) begin n_err++; $display("FAIL rnd_divider @%0d: got %0d expected %0d", cyc, divider, m_div); end
            n_vec++; if (en !== m_en) begin n_err++; $display("FAIL rnd_en @%0d: got %b expected %b", cyc, en, m_en); end
            n_vec++; if (ack !== m_ack) begin n_err++; $display("FAIL rnd_ack @%0d: got %b expected %b", cyc, ack, m_ack); end
            n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, busy, m_busy); end
            n_vec++; if (owner !== 2'(m_owner)) begin n_err++; $display("FAIL rnd_owner @%0d: got %0d expected %0d", cyc, owner, m_owner); end
            n_vec++; if (en === 1'b1 && divider !== prev_div) begin n_err++; $display("FAIL rnd_en_on_change @%0d: got div %0d->%0d with en=1", cyc, prev_div, divider); end
            prev_div = divider;
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req[i] = 1'b1;
                        div_req[16*i +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    div_req[16*i +: 16] = 16'($urandom);
                end
            end
            if (stop) begin
                if ($urandom_range(0, 5) == 0) stop = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                stop = 1'b1;
            end
        end
        stop = 1'b0;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stop_halt();
        test_stop_with_req();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Reconfiguration sequencer and arbiter for the programmable clock divider. It shares the divider between NUM_REQ requesters, each of which asks for a new division value. Every divisor change follows a safe gate-off, load, settle, gate-on sequence, so the divider never sees `divider` change while `en` is high. It sits between the control/register logic and the divider's `divider`/`en` inputs.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
DRAIN_CYCLES, 4, clk_in cycles `en` is held low before the divisor is loaded (1..255)
SETTLE_CYCLES, 2, clk_in cycles after the load before `en` is reasserted (1..255)
RESET_DIV, 16'd2, divisor value driven after reset

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester change request, level, held until ack
div_req  input  16*NUM_REQ  requested divisor; requester i uses bits [16*i+15:16*i]
stop  input  1  global halt; forces divider disabled while high
ack  output  NUM_REQ  one-cycle pulse to the served requester when its divisor is active
divider  output  16  divisor to the divider, registered
en  output  1  divider enable, registered
busy  output  1  high in DRAIN, LOAD, SETTLE and HALT
owner  output  max(1,clog2(NUM_REQ))  index of the last granted requester

Behaviour:
- Reset (async, rst_n=0): state=IDLE, divider=RESET_DIV, en=0, ack=0, busy=0, owner=0, rr_ptr=0, counter=0. Reset mid-sequence aborts it; no ack is issued for the aborted grant.
- States: IDLE, DRAIN, LOAD, SETTLE, RUN, HALT.
- IDLE: en=0.
  - stop=1 -> HALT.
  - Otherwise any eligible req -> grant -> DRAIN.
- Arbitration (IDLE and RUN only, with stop=0):
  - Round-robin search starts at rr_ptr; first req[i]=1 wins.
  - A requester whose ack is high this cycle is ineligible.
  - On grant: capture div_req[i] into a holding register, owner<=i, rr_ptr<=(i+1) mod NUM_REQ.
- DRAIN: en=0; counter runs DRAIN_CYCLES cycles -> LOAD.
- LOAD: one cycle; divider<=held value -> SETTLE.
- SETTLE: en=0; counter runs SETTLE_CYCLES cycles -> RUN.
- RUN entry edge: en<=1 and ack[owner]<=1 for exactly one cycle.
- RUN:
  - stop=1 -> HALT, with en<=0 on the same edge.
  - Otherwise an eligible req -> grant -> DRAIN (en<=0 on the grant edge).
- HALT: en=0; pending requests are neither granted nor acked.
  - stop=0 with a valid divisor (state was RUN before the halt) -> SETTLE, then RUN without ack.
  - stop=0 with no divisor ever loaded -> IDLE.
- Latency: req sampled in RUN/IDLE at edge t -> en=0 at t; LOAD at t+DRAIN_CYCLES; en=1 and ack at t+DRAIN_CYCLES+1+SETTLE_CYCLES. With defaults, ack arrives 7 edges after the grant edge.
- Requests from non-granted requesters during a sequence stay pending and are served in round-robin order afterwards.
- A requester dropping req before its grant is withdrawn silently. Changes to req/div_req after the grant are ignored until ack.
- Simultaneous events:
  - stop=1 in the same cycle as a req in RUN: stop wins.
  - stop asserted during DRAIN/LOAD/SETTLE is ignored until RUN entry, then HALT on the next edge. The ack still pulses on the RUN entry edge.
- busy=1 whenever state is not IDLE and not RUN. divider is stable except on the LOAD edge. en is never 1 on a LOAD edge.

Optional Feature:
Macro CLK_DIV_CTRL_MIN_CLAMP_EN.
- Defined: a captured divisor below 16'd2 is replaced by 16'd2 at capture, so the divider never enters its pass-through mode.
- Undefined: the divisor is passed unmodified, and 0/1 are legal.

Test Plan:
- Reset then req[0]=1, div_req[0]=16'd10, stop=0 -> en low 7 cycles after the grant edge (DRAIN, LOAD, SETTLE), divider=10 at LOAD, then en=1 and ack[0] one cycle.
- req[0..3] all high from RUN, rr_ptr=0 -> acks in order 0,1,2,3, each 8 edges apart. owner tracks the grant. en is never high while divider changes.
- RUN with divider=6; stop=1 for 5 cycles -> en=0 next edge, busy=1. After stop falls: SETTLE 2 cycles, en=1, no ack, divider still 6.
- stop=1 and req[2]=1 raised in the same RUN cycle -> HALT, no grant. After stop=0, req[2] is granted from RUN and acked with its divisor.
- rst_n pulsed low during SETTLE -> divider=RESET_DIV, en=0, ack never asserted, state IDLE.
- Clamp: div_req[1]=16'd1 -> divider=2 with CLK_DIV_CTRL_MIN_CLAMP_EN defined, divider=1 without it.
